// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU control constants and the per-state control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        aluop_t     aluop;
    } ctrl_t;

    // Moore control word for each state; anything not set stays 0 / add.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps (aluop, funct) to the ALU's alucontrol code.
// Unknown funct values fall back to add.
import mc_ctrl_pkg::*;

module mc_aludec #(
    parameter int OP_W   = 6,
    parameter int ACTL_W = 3
) (
    input  logic [1:0]        aluop,
    input  logic [OP_W-1:0]   funct,
    output logic [ACTL_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with registered control word.
// Optional feature: define MC_CTRL_BNE_EN to add bne support.
import mc_ctrl_pkg::*;

module mc_controller #(
    parameter int OP_W   = 6,
    parameter int ACTL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   funct,
    input  logic              zero,
    output logic              iord,
    output logic              memwrite,
    output logic              irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [ACTL_W-1:0] alucontrol,
    output logic              illegal_op
);

    state_t              state_q, state_d;
    ctrl_t               ctrl_q;
    logic                illegal_d;
    logic                is_bne;
    logic [ACTL_W-1:0]   dec_alucontrol;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word is precomputed from the next state so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    mc_aludec #(
        .OP_W   (OP_W),
        .ACTL_W (ACTL_W)
    ) u_aludec (
        .aluop      (ctrl_q.aluop),
        .funct      (funct),
        .alucontrol (dec_alucontrol)
    );

`ifdef MC_CTRL_BNE_EN
    assign is_bne = (op == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    // Reset overrides the registered word so nothing is written while it is held.
    assign iord       = ~reset & ctrl_q.iord;
    assign memwrite   = ~reset & ctrl_q.memwrite;
    assign irwrite    = ~reset & ctrl_q.irwrite;
    assign regdst     = ~reset & ctrl_q.regdst;
    assign memtoreg   = ~reset & ctrl_q.memtoreg;
    assign regwrite   = ~reset & ctrl_q.regwrite;
    assign alusrca    = ~reset & ctrl_q.alusrca;
    assign alusrcb    = reset ? 2'b00 : ctrl_q.alusrcb;
    assign pcsrc      = reset ? 2'b00 : ctrl_q.pcsrc;
    assign pcen       = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ is_bne)));
    assign alucontrol = reset ? ALU_ADD : dec_alucontrol;
    assign illegal_op = ~reset & illegal_d;

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller: expected per-cycle control
// words are queued per instruction and compared cycle by cycle.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BAD  = 6'b111111;

    mc_controller #(
        .OP_W   (6),
        .ACTL_W (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb[2],pcsrc[2],pcen,alucontrol[3],illegal_op
    function automatic logic [15:0] mk(input logic io, input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] ps, input logic pe,
                                       input logic [2:0] ac, input logic ill);
        return {io, mw, irw, rd, m2r, rw, asa, asb, ps, pe, ac, ill};
    endfunction

    function automatic logic [2:0] fmap(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] o);
        if (o == T_R || o == T_LW || o == T_SW || o == T_BEQ || o == T_ADDI || o == T_J) return 1'b1;
`ifdef MC_CTRL_BNE_EN
        if (o == T_BNE) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void push(input string tag, input logic [15:0] w);
        exp_q.push_back(w);
        tag_q.push_back(tag);
    endfunction

    task automatic step();
        logic [15:0] obs, e;
        string       t;
        @(negedge clk);
        obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal_op};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    task automatic push_fd(input string name, input logic [5:0] o);
        push({name, "/FETCH"},  mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0));
        push({name, "/DECODE"}, mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,~legal(o)));
    endtask

    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
        push_fd(name, o);
        case (o)
            T_LW: begin
                push({name, "/MEMADR"}, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
                push({name, "/MEMRD"},  mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
                push({name, "/MEMWB"},  mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0));
            end
            T_SW: begin
                push({name, "/MEMADR"}, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
                push({name, "/MEMWR"},  mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
            end
            T_R: begin
                push({name, "/EXECUTE"}, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,fmap(f),0));
                push({name, "/ALUWB"},   mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0));
            end
            T_BEQ:
                push({name, "/BRANCH"}, mk(0,0,0,0,0,0,1,2'b00,2'b01,z,3'b110,0));
`ifdef MC_CTRL_BNE_EN
            T_BNE:
                push({name, "/BRANCH"}, mk(0,0,0,0,0,0,1,2'b00,2'b01,~z,3'b110,0));
`endif
            T_ADDI: begin
                push({name, "/ADDIEX"}, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
                push({name, "/ADDIWB"}, mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0));
            end
            T_J:
                push({name, "/JUMP"}, mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0));
            default: ;
        endcase
        drain();
    endtask

    initial begin
        reset = 1'b1; op = T_R; funct = 6'b101010; zero = 1'b1;
        @(posedge clk);
        #1;
        push("reset0", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        push("reset1", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        drain();
        reset = 1'b0;

        run_instr("lw",        T_LW,   6'b000000, 1'b0);
        run_instr("r_slt",     T_R,    6'b101010, 1'b0);
        run_instr("r_add_z1",  T_R,    6'b100000, 1'b1);
        run_instr("r_sub",     T_R,    6'b100010, 1'b0);
        run_instr("r_and",     T_R,    6'b100100, 1'b0);
        run_instr("r_or",      T_R,    6'b100101, 1'b0);
        run_instr("r_unk",     T_R,    6'b000000, 1'b0);
        run_instr("sw",        T_SW,   6'b000000, 1'b1);
        run_instr("beq_z1",    T_BEQ,  6'b000000, 1'b1);
        run_instr("beq_z0",    T_BEQ,  6'b000000, 1'b0);
        run_instr("bne_z1",    T_BNE,  6'b000000, 1'b1);
        run_instr("bne_z0",    T_BNE,  6'b000000, 1'b0);
        run_instr("addi",      T_ADDI, 6'b000000, 1'b1);
        run_instr("j",         T_J,    6'b000000, 1'b0);
        run_instr("illegal",   T_BAD,  6'b000000, 1'b1);
        run_instr("after_ill", T_ADDI, 6'b000000, 1'b0);

        op = T_SW; funct = 6'b000000; zero = 1'b0;
        push_fd("sw_abort", T_SW);
        push("sw_abort/MEMADR", mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        drain();
        reset = 1'b1;
        push("sw_abort/reset_in_MEMWR", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        drain();
        reset = 1'b0;
        run_instr("post_reset_j", T_J, 6'b000000, 1'b0);
        run_instr("post_reset_lw", T_LW, 6'b000000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
